// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC, registered ALU flags and a per-run cycle counter,
// and runs one of P resident programs through a req/done handshake.
module prog_sequencer #(
  parameter int D      = 12,
  parameter int P      = 4,
  parameter int STRIDE = 256,
  parameter int CW     = 16,
  localparam int PW    = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [PW-1:0] prog_sel,
  input  logic          stall,
  input  logic          halt,
  input  logic [2:0]    br_cond,
  input  logic          br_rel,
  input  logic [7:0]    br_off,
  input  logic [D-1:0]  target,
  input  logic          zero,
  input  logic          pari,
  input  logic          sc_o,
  input  logic          flag_en,
  input  logic          sc_en,
  output logic [D-1:0]  prog_ctr,
  output logic          zeroQ,
  output logic          pariQ,
  output logic          sc_in,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cyc_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [D-1:0]  base, base_nx, pc_nx;
  logic [D-1:0]  sel_base, win_end, dest;
  logic          zero_nx, pari_nx, sc_nx;
  logic [CW-1:0] cyc_nx;
  logic          taken, sel_ok;

  assign sel_base = D'(prog_sel) * D'(STRIDE);
  assign sel_ok   = {1'b0, prog_sel} < (PW+1)'(P);
  assign win_end  = base + D'(STRIDE - 1);
  assign dest     = br_rel ? prog_ctr + D'($signed(br_off)) : target;

  // Conditions use the flags registered before this edge, never this cycle's updates.
  always_comb begin
    taken = 1'b0;
    unique case (br_cond)
      3'd0: taken = 1'b0;
      3'd1: taken = 1'b1;
      3'd2: taken = zeroQ;
      3'd3: taken = ~zeroQ;
      3'd4: taken = sc_in;
      3'd5: taken = ~sc_in;
      3'd6: taken = pariQ;
      3'd7: taken = ~pariQ;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    base_nx  = base;
    pc_nx    = prog_ctr;
    zero_nx  = zeroQ;
    pari_nx  = pariQ;
    sc_nx    = sc_in;
    cyc_nx   = cyc_cnt;
    unique case (state)
      IDLE: begin
        if (req && sel_ok) begin
          state_nx = RUN;
          base_nx  = sel_base;
          pc_nx    = sel_base;
          zero_nx  = 1'b0;
          pari_nx  = 1'b0;
          sc_nx    = 1'b0;
          cyc_nx   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (cyc_cnt != '1) cyc_nx = cyc_cnt + CW'(1);
          if (flag_en) begin
            zero_nx = zero;
            pari_nx = pari;
          end
          if (sc_en) sc_nx = sc_o;
          if (halt) state_nx = DONE;
          else if (prog_ctr == win_end && !taken) state_nx = DONE;
          else pc_nx = taken ? dest : prog_ctr + D'(1);
        end
      end
      DONE: begin
        if (!req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base     <= '0;
      prog_ctr <= '0;
      zeroQ    <= 1'b0;
      pariQ    <= 1'b0;
      sc_in    <= 1'b0;
      cyc_cnt  <= '0;
    end else begin
      state    <= state_nx;
      base     <= base_nx;
      prog_ctr <= pc_nx;
      zeroQ    <= zero_nx;
      pariQ    <= pari_nx;
      sc_in    <= sc_nx;
      cyc_cnt  <= cyc_nx;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: the bench acts as instruction ROM, an
// instruction-level model predicts per-step traces and run results.
module tb_prog_sequencer;
  localparam int D = 12, P = 4, STRIDE = 256, CW = 16;
  localparam int NADDR = 1 << D;

  logic clk = 1'b0, reset = 1'b1, req = 1'b0, stall = 1'b0;
  logic [1:0] prog_sel = '0;
  logic halt, br_rel, zero, pari, sc_o, flag_en, sc_en;
  logic [2:0] br_cond;
  logic [7:0] br_off;
  logic [D-1:0] target, prog_ctr;
  logic zeroQ, pariQ, sc_in, busy, done;
  logic [CW-1:0] cyc_cnt;

  logic s_req = 1'b0;
  logic [1:0] s_sel = '0;
  logic [D-1:0] s_pc;
  logic s_zq, s_pq, s_sc, s_busy, s_done;
  logic [3:0] s_cyc;

  typedef struct packed {
    logic halt; logic [2:0] bc; logic rel; logic [7:0] off; logic [D-1:0] tgt;
    logic zero; logic pari; logic sc_o; logic fe; logic se;
  } instr_t;
  typedef struct packed {
    logic [D-1:0] pc; logic z; logic p; logic s; logic [CW-1:0] cyc;
  } obs_t;

  instr_t rom [NADDR];
  instr_t cur;
  obs_t trace_q[$], end_q[$], tmp_q[$];
  int checks = 0, errors = 0;
  bit sb_en = 1'b1;
  logic done_prev = 1'b0;

  assign cur     = rom[prog_ctr];
  assign halt    = cur.halt;
  assign br_cond = cur.bc;
  assign br_rel  = cur.rel;
  assign br_off  = cur.off;
  assign target  = cur.tgt;
  assign zero    = cur.zero;
  assign pari    = cur.pari;
  assign sc_o    = cur.sc_o;
  assign flag_en = cur.fe;
  assign sc_en   = cur.se;

  prog_sequencer #(.D(D), .P(P), .STRIDE(STRIDE), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .stall(stall),
    .halt(halt), .br_cond(br_cond), .br_rel(br_rel), .br_off(br_off), .target(target),
    .zero(zero), .pari(pari), .sc_o(sc_o), .flag_en(flag_en), .sc_en(sc_en),
    .prog_ctr(prog_ctr), .zeroQ(zeroQ), .pariQ(pariQ), .sc_in(sc_in),
    .busy(busy), .done(done), .cyc_cnt(cyc_cnt));

  prog_sequencer #(.D(12), .P(3), .STRIDE(256), .CW(4)) u_small (
    .clk(clk), .reset(reset), .req(s_req), .prog_sel(s_sel), .stall(1'b0),
    .halt(1'b0), .br_cond(3'd0), .br_rel(1'b0), .br_off(8'd0), .target(12'd0),
    .zero(1'b0), .pari(1'b0), .sc_o(1'b0), .flag_en(1'b0), .sc_en(1'b0),
    .prog_ctr(s_pc), .zeroQ(s_zq), .pariQ(s_pq), .sc_in(s_sc),
    .busy(s_busy), .done(s_done), .cyc_cnt(s_cyc));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic bit cond_met(input logic [2:0] bc, input bit z, input bit s, input bit p);
    case (bc)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return z;
      3'd3: return !z;
      3'd4: return s;
      3'd5: return !s;
      3'd6: return p;
      default: return !p;
    endcase
  endfunction

  // Instruction-level reference: one loop iteration per executed instruction.
  task automatic run_model(input int base, output bit ok, output obs_t fin);
    int pc = base, cyc = 0;
    bit z = 0, p = 0, s = 0, tk;
    instr_t in;
    obs_t o;
    tmp_q.delete();
    ok = 1'b0;
    fin = '0;
    for (int step = 0; step < 500; step++) begin
      o.pc = D'(pc); o.z = z; o.p = p; o.s = s; o.cyc = CW'(cyc);
      tmp_q.push_back(o);
      in = rom[pc];
      tk = cond_met(in.bc, z, s, p);
      if (cyc < (1 << CW) - 1) cyc++;
      if (in.fe) begin z = in.zero; p = in.pari; end
      if (in.se) s = in.sc_o;
      if (in.halt || (pc == base + STRIDE - 1 && !tk)) begin
        ok = 1'b1;
        fin.pc = D'(pc); fin.z = z; fin.p = p; fin.s = s; fin.cyc = CW'(cyc);
        return;
      end
      if (!tk) pc = (pc + 1) % NADDR;
      else if (in.rel) pc = (pc + int'($signed(in.off)) + NADDR) % NADDR;
      else pc = int'(in.tgt);
    end
  endtask

  task automatic fill_plain;
    for (int a = 0; a < NADDR; a++) rom[a] = '0;
  endtask

  task automatic fill_random;
    for (int a = 0; a < NADDR; a++) begin
      rom[a]      = '0;
      rom[a].halt = ($urandom % 40) == 0;
      rom[a].bc   = (($urandom % 5) == 0) ? 3'($urandom) : 3'd0;
      rom[a].rel  = ($urandom % 4) != 0;
      rom[a].off  = ($urandom % 2) ? 8'($urandom_range(0, 16) - 8) : 8'($urandom);
      rom[a].tgt  = D'($urandom);
      rom[a].zero = 1'($urandom);
      rom[a].pari = 1'($urandom);
      rom[a].sc_o = 1'($urandom);
      rom[a].fe   = ($urandom % 3) == 0;
      rom[a].se   = ($urandom % 3) == 0;
    end
  endtask

  task automatic prep_random(input int base);
    bit ok;
    obs_t fin;
    for (int t = 0; t < 30; t++) begin
      fill_random();
      run_model(base, ok, fin);
      if (ok) return;
    end
    fill_plain();
  endtask

  task automatic do_run(input int sel);
    bit ok;
    obs_t fin;
    int base = sel * STRIDE;
    int n = 0;
    run_model(base, ok, fin);
    foreach (tmp_q[i]) trace_q.push_back(tmp_q[i]);
    end_q.push_back(fin);
    prog_sel = 2'(sel);
    req = 1'b1;
    tick;
    check("accept_busy", busy, 1);
    check("accept_pc", prog_ctr, base);
    while (!done && n < 3000) begin
      stall = ($urandom % 4) == 0;
      req = 1'($urandom);
      tick;
      n++;
    end
    check("run_done", done, 1);
    if (!done) begin
      reset = 1'b1;
      tick;
      reset = 1'b0;
      trace_q.delete();
      end_q.delete();
    end else begin
      stall = 1'b0;
      req = 1'b1;
      repeat (2) begin
        tick;
        check("hold_done", done, 1);
        check("hold_busy", busy, 0);
      end
      req = 1'b0;
      tick;
      check("drop_done", done, 0);
      check("drop_pc", prog_ctr, fin.pc);
      check("drop_cyc", cyc_cnt, fin.cyc);
      tick;
      check("idle_busy", busy, 0);
    end
  endtask

  always @(negedge clk) begin
    obs_t t;
    if (!reset && sb_en) begin
      if (busy && !stall) begin
        if (trace_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL trace_extra actual_pc=0x%0h required=no_step", prog_ctr);
        end else begin
          t = trace_q.pop_front();
          check("step_pc", prog_ctr, t.pc);
          check("step_zeroQ", zeroQ, t.z);
          check("step_pariQ", pariQ, t.p);
          check("step_sc_in", sc_in, t.s);
          check("step_cyc", cyc_cnt, t.cyc);
        end
      end
      if (done && !done_prev) begin
        check("end_trace_left", trace_q.size(), 0);
        trace_q.delete();
        if (end_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL end_extra actual=done required=no_done");
        end else begin
          t = end_q.pop_front();
          check("end_pc", prog_ctr, t.pc);
          check("end_zeroQ", zeroQ, t.z);
          check("end_pariQ", pariQ, t.p);
          check("end_sc_in", sc_in, t.s);
          check("end_cyc", cyc_cnt, t.cyc);
          check("end_busy", busy, 0);
        end
      end
    end
    done_prev = done;
  end

  initial begin
    fill_plain();
    repeat (2) tick;
    reset = 1'b0;
    tick;
    check("rst_pc", prog_ctr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cyc", cyc_cnt, 0);
    check("rst_flags", {zeroQ, pariQ, sc_in}, 0);

    // Small instance: P=3 rejects index 3; CW=4 saturates.
    s_sel = 2'd3; s_req = 1'b1;
    repeat (2) tick;
    check("p3_ignored_busy", s_busy, 0);
    check("p3_ignored_pc", s_pc, 0);
    s_sel = 2'd1;
    tick;
    check("small_busy", s_busy, 1);
    check("small_pc", s_pc, 12'h100);
    s_req = 1'b0;
    repeat (14) tick;
    check("small_cyc14", s_cyc, 14);
    repeat (6) tick;
    check("small_cyc_sat", s_cyc, 15);
    check("small_pc20", s_pc, 12'h114);

    fill_plain();
    rom[12'h205].halt = 1'b1;
    do_run(2);
    check("halt205_pc", prog_ctr, 12'h205);
    check("halt205_cyc", cyc_cnt, 6);

    fill_plain();
    do_run(0);
    check("win0_pc", prog_ctr, 12'h0FF);
    check("win0_cyc", cyc_cnt, 256);

    fill_plain();
    rom[12'h100].fe = 1'b1;
    rom[12'h101].bc = 3'd2; rom[12'h101].rel = 1'b1; rom[12'h101].off = 8'hFF;
    rom[12'h102].halt = 1'b1;
    do_run(1);
    check("nottaken_pc", prog_ctr, 12'h102);

    rom[12'h100].zero = 1'b1;
    rom[12'h101].off = 8'h03;
    rom[12'h104].halt = 1'b1;
    do_run(1);
    check("taken_pc", prog_ctr, 12'h104);

    for (int r = 0; r < 12; r++) begin
      int sel = $urandom_range(0, P - 1);
      prep_random(sel * STRIDE);
      do_run(sel);
    end

    // Reset while busy with all flags set.
    sb_en = 1'b0;
    fill_plain();
    for (int a = 0; a < NADDR; a++) begin
      rom[a].fe = 1'b1; rom[a].zero = 1'b1; rom[a].pari = 1'b1;
      rom[a].se = 1'b1; rom[a].sc_o = 1'b1;
    end
    prog_sel = 2'd3; req = 1'b1; stall = 1'b0;
    tick;
    req = 1'b0;
    for (int n = 0; n < 20 && prog_ctr != 12'h304; n++) tick;
    check("pre_rst_pc", prog_ctr, 12'h304);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_flags", {zeroQ, pariQ, sc_in}, 3'b111);
    reset = 1'b1;
    tick;
    check("midrst_pc", prog_ctr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_flags", {zeroQ, pariQ, sc_in}, 0);
    check("midrst_cyc", cyc_cnt, 0);
    reset = 1'b0;
    tick;
    check("postrst_busy", busy, 0);

    check("queues_empty", trace_q.size() + end_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
